// File: rtl/window_fetch_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : window_fetch_ctrl_if
// Purpose  : Bundles the frame handshake, image-memory read port and window
//            datapath strobes used by window_fetch_ctrl.
// Ports    : master - the fetch controller (drives memory/window/status)
//            slave  - the surrounding system (drives Start/Hold)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface window_fetch_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int CRD_W  = 8
);
  // frame handshake
  logic              Start;
  logic              Hold;
  logic              Busy;
  logic              Complete;
  // image memory read port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  // window datapath strobes
  logic              shift_en;
  logic              win_valid;
  logic [CRD_W-1:0]  win_row;
  logic [CRD_W-1:0]  win_col;

  modport master (
    input  Start, Hold,
    output Busy, Complete, mem_addr, mem_en,
    output shift_en, win_valid, win_row, win_col
  );

  modport slave (
    output Start, Hold,
    input  Busy, Complete, mem_addr, mem_en,
    input  shift_en, win_valid, win_row, win_col
  );
endinterface

`default_nettype wire

// File: rtl/window_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : window_fetch_ctrl
// Purpose  : Streams one raster frame out of the byte-wide image memory into
//            the 3x3 window datapath. Issues sequential reads, produces the
//            line-buffer shift strobe aligned to returning data, flags full
//            interior windows with their centre coordinates and reports frame
//            completion through the Start/Complete handshake.
// Ports    : CLK       - system clock, rising edge
//            RST_N     - asynchronous active-low reset
//            bus       - window_fetch_ctrl_if.master
//              Start     in  level request to process one frame
//              Hold      in  back-pressure, suppresses new reads
//              mem_addr  out read address
//              mem_en    out read enable (one read per cycle)
//              shift_en  out read data valid, shift line buffers/window
//              win_valid out window after this shift is a full 3x3
//              win_row   out window centre row (held between windows)
//              win_col   out window centre column (held between windows)
//              Busy      out frame in progress
//              Complete  out frame finished, held until Start falls
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module window_fetch_ctrl #(
  parameter int IMG_W  = 256,
  parameter int IMG_H  = 256,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1,
  parameter int CRD_W  = 8
) (
  input  wire logic            CLK,
  input  wire logic            RST_N,
  window_fetch_ctrl_if.master  bus
);

  //--------------------------------------------------------------------------
  // Constants
  //--------------------------------------------------------------------------
  localparam int               c_NPIX      = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_NPIX - 1);
  localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
  localparam logic [CRD_W-1:0]  c_LAST_COL  = CRD_W'(IMG_W - 1);
  localparam logic [CRD_W-1:0]  c_LAST_ROW  = CRD_W'(IMG_H - 1);
  localparam logic [CRD_W-1:0]  c_CRD_ONE   = CRD_W'(1);
  localparam logic [CRD_W-1:0]  c_CRD_TWO   = CRD_W'(2);

  //--------------------------------------------------------------------------
  // State machine encoding
  //--------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [ADDR_W-1:0]  r_rd_cnt;
  logic               w_mem_en;
  logic               w_frame_start;
  logic               w_shift_en;

  logic [CRD_W-1:0]   r_col;
  logic [CRD_W-1:0]   r_row;
  logic               w_pix_last;
  logic               w_win_valid;
  logic [CRD_W-1:0]   w_ctr_row;
  logic [CRD_W-1:0]   w_ctr_col;
  logic [CRD_W-1:0]   r_win_row;
  logic [CRD_W-1:0]   r_win_col;

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state and read-issue logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_mem_en      = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_state_nxt   = S_FETCH;
          w_frame_start = 1'b1;
        end
      end
      S_FETCH: begin
        w_mem_en = ~bus.Hold;
        // A held cycle defers the final read, so only an issued read of the
        // last address ends the fetch phase.
        if (w_mem_en && (r_rd_cnt == c_LAST_ADDR)) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final pixel's shift is the last in-flight read returning;
        // leaving here makes Complete rise exactly one cycle later.
        if (w_shift_en && w_pix_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!bus.Start) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Read address counter. It parks on the last address instead of stepping
  // past it, so the address bus never shows an out-of-frame value.
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_cnt <= '0;
    end else if (w_frame_start) begin
      r_rd_cnt <= '0;
    end else if (w_mem_en && (r_rd_cnt != c_LAST_ADDR)) begin
      r_rd_cnt <= r_rd_cnt + c_ADDR_ONE;
    end
  end

  //--------------------------------------------------------------------------
  // Read-data alignment: shift_en is mem_en delayed by RD_LAT cycles. Reads
  // already in the pipe complete regardless of Hold.
  //--------------------------------------------------------------------------
  generate
    if (RD_LAT == 1) begin : g_lat_one
      logic r_pipe;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_pipe <= 1'b0;
        end else begin
          r_pipe <= w_mem_en;
        end
      end
      assign w_shift_en = r_pipe;
    end else begin : g_lat_multi
      logic [RD_LAT-1:0] r_pipe;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_pipe <= '0;
        end else begin
          r_pipe <= {r_pipe[RD_LAT-2:0], w_mem_en};
        end
      end
      assign w_shift_en = r_pipe[RD_LAT-1];
    end
  endgenerate

  //--------------------------------------------------------------------------
  // Pixel position of the data being shifted in, kept as column/row wrap
  // counters so no divider is needed.
  //--------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_frame_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_shift_en) begin
      if (r_col == c_LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == c_LAST_ROW) ? '0 : (r_row + c_CRD_ONE);
      end else begin
        r_col <= r_col + c_CRD_ONE;
      end
    end
  end

  assign w_pix_last  = (r_col == c_LAST_COL) && (r_row == c_LAST_ROW);

  // The pixel being shifted is the bottom-right tap; the window is complete
  // once two full rows and two columns precede it.
  assign w_win_valid = w_shift_en && (r_row >= c_CRD_TWO) && (r_col >= c_CRD_TWO);
  assign w_ctr_row   = r_row - c_CRD_ONE;
  assign w_ctr_col   = r_col - c_CRD_ONE;

  // Coordinates are presented combinationally with win_valid and otherwise
  // hold the last reported window centre.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_win_row <= '0;
      r_win_col <= '0;
    end else if (w_win_valid) begin
      r_win_row <= w_ctr_row;
      r_win_col <= w_ctr_col;
    end
  end

  //--------------------------------------------------------------------------
  // Outputs
  //--------------------------------------------------------------------------
  assign bus.mem_addr  = r_rd_cnt;
  assign bus.mem_en    = w_mem_en;
  assign bus.shift_en  = w_shift_en;
  assign bus.win_valid = w_win_valid;
  assign bus.win_row   = w_win_valid ? w_ctr_row : r_win_row;
  assign bus.win_col   = w_win_valid ? w_ctr_col : r_win_col;
  assign bus.Busy      = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign bus.Complete  = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_window_fetch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_window_fetch_ctrl
// Purpose  : Bench for window_fetch_ctrl on an 8x8 image, with one instance at
//            read latency 1 and one at read latency 3 sharing Start/Hold/reset.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_window_fetch_ctrl;

  localparam int IMG_W  = 8;
  localparam int IMG_H  = 8;
  localparam int ADDR_W = 16;
  localparam int CRD_W  = 8;
  localparam int NPIX   = IMG_W * IMG_H;
  localparam int NWIN   = (IMG_W - 2) * (IMG_H - 2);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic hold  = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  //--------------------------------------------------------------------------
  // Two instances (RD_LAT 1 and 3) with a per-instance reference model.
  // The model works in terms of reads issued, shifts returned and a queue of
  // return times; the pixel index of each shift is simply the return order.
  //--------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = (g == 0) ? 1 : 3;

    window_fetch_ctrl_if #(.ADDR_W(ADDR_W), .CRD_W(CRD_W)) bus ();

    assign bus.Start = start;
    assign bus.Hold  = hold;

    window_fetch_ctrl #(
      .IMG_W (IMG_W),
      .IMG_H (IMG_H),
      .ADDR_W(ADDR_W),
      .RD_LAT(LAT),
      .CRD_W (CRD_W)
    ) dut (
      .CLK  (clk),
      .RST_N(rst_n),
      .bus  (bus)
    );

    // 0: waiting for Start, 1: frame running, 2: frame complete
    int mode     = 0;
    int issued   = 0;
    int shifted  = 0;
    int n_win    = 0;
    int cyc      = 0;
    int last_row = 0;
    int last_col = 0;
    int due_q[$];
    bit e_en, e_sh, e_wv;
    int p, r, c;

    always @(negedge clk) begin
      if (!rst_n) begin
        mode     = 0;
        issued   = 0;
        shifted  = 0;
        n_win    = 0;
        last_row = 0;
        last_col = 0;
        due_q.delete();
      end else begin
        e_en = (mode == 1) && (issued < NPIX) && !hold;
        e_sh = (due_q.size() > 0) && (due_q[0] == cyc);
        e_wv = 1'b0;
        if (e_sh) begin
          p = shifted;
          r = p / IMG_W;
          c = p % IMG_W;
          e_wv = (r >= 2) && (c >= 2);
          if (e_wv) begin
            last_row = r - 1;
            last_col = c - 1;
          end
        end
        chk($sformatf("L%0d mem_en c%0d", LAT, cyc), bus.mem_en, e_en);
        if (e_en) chk($sformatf("L%0d mem_addr c%0d", LAT, cyc), bus.mem_addr, issued);
        chk($sformatf("L%0d shift_en c%0d", LAT, cyc), bus.shift_en, e_sh);
        chk($sformatf("L%0d win_valid c%0d", LAT, cyc), bus.win_valid, e_wv);
        chk($sformatf("L%0d win_row c%0d", LAT, cyc), bus.win_row, last_row);
        chk($sformatf("L%0d win_col c%0d", LAT, cyc), bus.win_col, last_col);
        chk($sformatf("L%0d Busy c%0d", LAT, cyc), bus.Busy, (mode == 1));
        chk($sformatf("L%0d Complete c%0d", LAT, cyc), bus.Complete, (mode == 2));

        if (e_en) begin
          due_q.push_back(cyc + LAT);
          issued++;
        end
        if (e_sh) begin
          void'(due_q.pop_front());
          shifted++;
          if (e_wv) n_win++;
        end
        if (mode == 0 && start) begin
          mode    = 1;
          issued  = 0;
          shifted = 0;
          n_win   = 0;
        end else if (mode == 1 && shifted == NPIX) begin
          mode = 2;
          chk($sformatf("L%0d windows per frame", LAT), n_win, NWIN);
          chk($sformatf("L%0d reads per frame", LAT), issued, NPIX);
        end else if (mode == 2 && !start) begin
          mode = 0;
        end
      end
      cyc++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string tag, input int limit);
    int k = 0;
    while (!g_inst[1].bus.Complete && k < limit) begin
      step(1);
      k++;
    end
    chk({tag, " completion timeout"}, (k < limit), 1'b1);
  endtask

  task automatic wait_addr(input string tag, input int addr, input int limit);
    int k = 0;
    while (g_inst[0].bus.mem_addr != addr[ADDR_W-1:0] && k < limit) begin
      step(1);
      k++;
    end
    chk({tag, " address timeout"}, (k < limit), 1'b1);
  endtask

  initial begin
    int k;

    // Reset state
    rst_n = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    step(3);
    chk("rst L1 addr/en/shift", {g_inst[0].bus.mem_addr, g_inst[0].bus.mem_en, g_inst[0].bus.shift_en}, 0);
    chk("rst L1 win/status", {g_inst[0].bus.win_valid, g_inst[0].bus.win_row, g_inst[0].bus.win_col,
                              g_inst[0].bus.Busy, g_inst[0].bus.Complete}, 0);
    chk("rst L3 addr/en/shift", {g_inst[1].bus.mem_addr, g_inst[1].bus.mem_en, g_inst[1].bus.shift_en}, 0);
    chk("rst L3 win/status", {g_inst[1].bus.win_valid, g_inst[1].bus.win_row, g_inst[1].bus.win_col,
                              g_inst[1].bus.Busy, g_inst[1].bus.Complete}, 0);
    rst_n = 1'b1;
    step(2);

    // Frame 1: Start held, no Hold; Complete must stay while Start is held
    start = 1'b1;
    wait_done("frame1", 300);
    step(5);
    chk("held Start keeps Complete", g_inst[1].bus.Complete, 1'b1);
    chk("held Start issues no reads", g_inst[0].bus.mem_en, 1'b0);
    start = 1'b0;
    step(3);

    // Frame 2: Hold for 5 cycles with the read counter at 20
    start = 1'b1;
    wait_addr("frame2", 20, 100);
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("hold addr frozen %0d", i), g_inst[0].bus.mem_addr, 20);
      chk($sformatf("hold no read %0d", i), g_inst[1].bus.mem_en, 1'b0);
      @(posedge clk);
      #1;
    end
    hold = 1'b0;
    wait_done("frame2", 300);
    start = 1'b0;
    step(3);

    // Frame 3: Start pulsed (falls mid-frame), random back-pressure
    start = 1'b1;
    step(1);
    start = 1'b0;
    k = 0;
    while (!g_inst[1].bus.Complete && k < 2000) begin
      hold = ($urandom_range(0, 3) == 0);
      step(1);
      k++;
    end
    hold = 1'b0;
    chk("frame3 completion timeout", (k < 2000), 1'b1);
    step(3);

    // Frame 4: asynchronous reset mid-frame, then restart with Start held
    start = 1'b1;
    wait_addr("frame4", 30, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst L1 addr/en/shift", {g_inst[0].bus.mem_addr, g_inst[0].bus.mem_en, g_inst[0].bus.shift_en}, 0);
    chk("async rst L1 win/status", {g_inst[0].bus.win_valid, g_inst[0].bus.win_row, g_inst[0].bus.win_col,
                                    g_inst[0].bus.Busy, g_inst[0].bus.Complete}, 0);
    chk("async rst L3 addr/en/shift", {g_inst[1].bus.mem_addr, g_inst[1].bus.mem_en, g_inst[1].bus.shift_en}, 0);
    chk("async rst L3 win/status", {g_inst[1].bus.win_valid, g_inst[1].bus.win_row, g_inst[1].bus.win_col,
                                    g_inst[1].bus.Busy, g_inst[1].bus.Complete}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1);
    chk("restart first read", g_inst[0].bus.mem_en, 1'b1);
    chk("restart addr 0", g_inst[0].bus.mem_addr, 0);
    wait_done("frame4", 300);
    start = 1'b0;
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
